// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: tags SPI bytes with synchronised D/C, buffers them, replays them as spaced strobes (ports: clk_in, rst_in, dc_in, byte_rdy_in, byte_data_in, flush_in, clr_ovf_in -> byte_rdy_out, byte_data_out, dc_out, level_out, overflow_out)
module spi_byte_fifo #(
  parameter int DEPTH       = 16,
  parameter int MIN_SPACING = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     dc_in,
  input  logic                     byte_rdy_in,
  input  logic [7:0]               byte_data_in,
  input  logic                     flush_in,
  input  logic                     clr_ovf_in,
  output logic                     byte_rdy_out,
  output logic [7:0]               byte_data_out,
  output logic                     dc_out,
  output logic [$clog2(DEPTH):0]   level_out,
  output logic                     overflow_out
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;
  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic [7:0]  cnt_q, cnt_d, data_q, data_d;
  logic        dc_s1_q, dc_s2_q, dc_out_q, dc_out_d, rdy_q, rdy_d, ovf_q, ovf_d;
  logic [8:0]  mem_q [DEPTH];
  logic        empty, full, push, pop;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push  = byte_rdy_in && !full && !flush_in;
  assign pop   = state_q == IDLE && !empty && !flush_in;
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = flush_in ? wr_ptr_q : rd_ptr_q + (AW+1)'(pop);
    level_d  = wr_ptr_d - rd_ptr_d;
    ovf_d    = (byte_rdy_in && full) || (ovf_q && !clr_ovf_in);
    rdy_d    = pop;
    data_d   = pop ? mem_q[rd_ptr_q[AW-1:0]][7:0] : data_q;
    dc_out_d = pop ? mem_q[rd_ptr_q[AW-1:0]][8] : dc_out_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: state_d = pop ? EMIT : IDLE;
      EMIT: begin
        // EMIT and the next IDLE account for two cycles of the spacing; GAP covers the rest
        state_d = (MIN_SPACING <= 2) ? IDLE : GAP;
        cnt_d   = 8'(MIN_SPACING - 2);
      end
      GAP: begin
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q <= 8'd1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    if (flush_in) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      dc_out_q <= 1'b0;
      rdy_q    <= 1'b0;
      ovf_q    <= 1'b0;
      dc_s1_q  <= 1'b0;
      dc_s2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      dc_out_q <= dc_out_d;
      rdy_q    <= rdy_d;
      ovf_q    <= ovf_d;
      dc_s1_q  <= dc_in;
      dc_s2_q  <= dc_s1_q;
    end
  end
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {dc_s2_q, byte_data_in};
  end
  assign byte_rdy_out  = rdy_q;
  assign byte_data_out = data_q;
  assign dc_out        = dc_out_q;
  assign level_out     = level_q;
  assign overflow_out  = ovf_q;
endmodule
